jt900h_intc: RTL and testbench

//  Interrupt controller driving the jt900h CPU interrupt inputs (irq, int_lvl, int_addr) and

---
 rtl/jt900h_intc.sv | 133 +++++++++++++
 tb/tb_jt900h_intc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_intc.sv
// Interrupt controller for the jt900h CPU: latches NSRC requests, arbitrates by programmable
// level and presents one vector at a time through an irq/irq_ack handshake.
module jt900h_intc #(
   parameter int         NSRC  = 8,
   parameter logic [7:0] VBASE = 8'h20
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen,
   input  logic [NSRC-1:0] src,
   output logic            irq,
   output logic [2:0]      int_lvl,
   output logic [7:0]      int_addr,
   input  logic            irq_ack,
   input  logic [4:0]      cfg_addr,
   input  logic [7:0]      cfg_din,
   input  logic            cfg_we,
   output logic [7:0]      cfg_dout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   logic [NSRC-1:0] pend, pend_nxt, src_l, mode, clr;
   logic [2:0]      prio [NSRC];
   logic [7:0]      vec  [NSRC];
   logic [1:0]      state;
   logic [2:0]      win, best_idx, best_lvl;
   logic            has_cand;

   // Strictly-greater compare keeps the lowest index on a priority tie
   always_comb begin
      best_idx = '0;
      best_lvl = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (pend[i] && prio[i] > best_lvl) begin
            best_lvl = prio[i];
            best_idx = 3'(i);
         end
      end
   end

   assign has_cand = best_lvl != 3'd0;

   // A fresh edge wins over a simultaneous ack or W1C clear; level bits just follow src
   always_comb begin
      clr = '0;
      if (state == ST_REQ && has_cand && irq_ack)
         clr[win] = mode[win];
      if (cfg_we && cfg_addr == 5'd16)
         clr = clr | cfg_din[NSRC-1:0];
      for (int i = 0; i < NSRC; i++)
         pend_nxt[i] = mode[i] ? ((src[i] & ~src_l[i]) | (pend[i] & ~clr[i])) : src[i];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend  <= '0;
         src_l <= '0;
         mode  <= '0;
         for (int i = 0; i < NSRC; i++) begin
            prio[i] <= '0;
            vec[i]  <= VBASE + 8'(4 * i);
         end
      end else if (cen) begin
         src_l <= src;
         pend  <= pend_nxt;
         if (cfg_we) begin
            for (int i = 0; i < NSRC; i++) begin
               if (cfg_addr == 5'(i))
                  {mode[i], prio[i]} <= cfg_din[3:0];
               if (cfg_addr == 5'(8 + i))
                  vec[i] <= cfg_din;
            end
         end
      end
   end

   // REQ keeps re-sampling the winner so a higher request can preempt before the ack
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         irq      <= 1'b0;
         int_lvl  <= '0;
         int_addr <= '0;
         win      <= '0;
      end else if (cen) begin
         case (state)
            ST_IDLE: begin
               if (has_cand) begin
                  win      <= best_idx;
                  int_lvl  <= best_lvl;
                  int_addr <= vec[best_idx];
                  irq      <= 1'b1;
                  state    <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (!has_cand) begin
                  irq   <= 1'b0;
                  state <= ST_IDLE;
               end else if (irq_ack) begin
                  irq   <= 1'b0;
                  state <= ST_ACK;
               end else begin
                  win      <= best_idx;
                  int_lvl  <= best_lvl;
                  int_addr <= vec[best_idx];
               end
            end
            ST_ACK: begin
               if (!irq_ack)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cfg_dout = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (cfg_addr == 5'(i))
            cfg_dout = {4'd0, mode[i], prio[i]};
         if (cfg_addr == 5'(8 + i))
            cfg_dout = vec[i];
      end
      if (cfg_addr == 5'd16)
         cfg_dout[NSRC-1:0] = pend;
   end

endmodule

// File: tb/tb_jt900h_intc.sv
// Directed bench for jt900h_intc: reset, single edge, priority/tie, preemption,
// level sources, cen gating and set/clear collisions.
module tb_jt900h_intc;

   logic       clk = 1'b0;
   logic       rst_n, cen, irq, irq_ack, cfg_we;
   logic [7:0] src, cfg_din, cfg_dout, int_addr;
   logic [2:0] int_lvl;
   logic [4:0] cfg_addr;
   int         tests = 0;
   int         failures = 0;

   jt900h_intc #(.NSRC(8), .VBASE(8'h20)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .src(src),
      .irq(irq), .int_lvl(int_lvl), .int_addr(int_addr), .irq_ack(irq_ack),
      .cfg_addr(cfg_addr), .cfg_din(cfg_din), .cfg_we(cfg_we), .cfg_dout(cfg_dout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic writeReg(input logic [4:0] a, input logic [7:0] d);
      cfg_addr = a;
      cfg_din  = d;
      cfg_we   = 1'b1;
      applyStimulus(1);
      cfg_we   = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkReg(input string tag, input logic [4:0] a, input logic [7:0] exp);
      cfg_addr = a;
      #1;
      checkOutput(tag, cfg_dout, exp);
   endtask

   task automatic ackCycle();
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      applyStimulus(1);
   endtask

   initial begin
      rst_n = 1'b0; cen = 1'b1; src = '0; irq_ack = 1'b0;
      cfg_addr = '0; cfg_din = '0; cfg_we = 1'b0;
      applyStimulus(2);
      rst_n = 1'b1;
      applyStimulus(1);

      // reset state
      checkOutput("rst_irq", {7'd0, irq}, 8'h00);
      checkOutput("rst_lvl", {5'd0, int_lvl}, 8'h00);
      checkOutput("rst_addr", int_addr, 8'h00);
      checkReg("rst_vec1", 5'd9, 8'h24);

      // single edge source, prio 5
      writeReg(5'd2, 8'h0D);
      src[2] = 1'b1;
      applyStimulus(1);
      checkReg("edge_pend", 5'd16, 8'h04);
      checkOutput("edge_irq_early", {7'd0, irq}, 8'h00);
      applyStimulus(1);
      checkOutput("edge_irq", {7'd0, irq}, 8'h01);
      checkOutput("edge_lvl", {5'd0, int_lvl}, 8'h05);
      checkOutput("edge_addr", int_addr, 8'h28);
      src[2] = 1'b0;
      irq_ack = 1'b1;
      applyStimulus(1);
      checkOutput("ack_irq", {7'd0, irq}, 8'h00);
      irq_ack = 1'b0;
      applyStimulus(2);
      checkOutput("ack_irq_idle", {7'd0, irq}, 8'h00);
      checkReg("ack_pend", 5'd16, 8'h00);

      // priority and tie
      writeReg(5'd0, 8'h0B);
      writeReg(5'd5, 8'h0E);
      src[0] = 1'b1; src[5] = 1'b1;
      applyStimulus(2);
      checkOutput("prio_lvl", {5'd0, int_lvl}, 8'h06);
      checkOutput("prio_addr", int_addr, 8'h34);
      writeReg(5'd0, 8'h0E);
      applyStimulus(1);
      checkOutput("tie_lvl", {5'd0, int_lvl}, 8'h06);
      checkOutput("tie_addr", int_addr, 8'h20);
      ackCycle();
      applyStimulus(1);
      checkOutput("tie_next_irq", {7'd0, irq}, 8'h01);
      checkOutput("tie_next_addr", int_addr, 8'h34);
      ackCycle();
      applyStimulus(1);
      checkOutput("tie_done_irq", {7'd0, irq}, 8'h00);
      src[0] = 1'b0; src[5] = 1'b0;
      writeReg(5'd0, 8'h00);
      writeReg(5'd5, 8'h00);

      // preemption before ack
      writeReg(5'd1, 8'h0A);
      writeReg(5'd4, 8'h0F);
      src[1] = 1'b1;
      applyStimulus(2);
      checkOutput("pre_lvl_lo", {5'd0, int_lvl}, 8'h02);
      checkOutput("pre_addr_lo", int_addr, 8'h24);
      src[4] = 1'b1;
      applyStimulus(2);
      checkOutput("pre_lvl_hi", {5'd0, int_lvl}, 8'h07);
      checkOutput("pre_addr_hi", int_addr, 8'h30);
      irq_ack = 1'b1;
      applyStimulus(1);
      checkOutput("pre_ack_irq", {7'd0, irq}, 8'h00);
      checkOutput("pre_frozen_lvl", {5'd0, int_lvl}, 8'h07);
      checkReg("pre_pend", 5'd16, 8'h02);
      irq_ack = 1'b0;
      applyStimulus(2);
      checkOutput("pre_rereq_irq", {7'd0, irq}, 8'h01);
      checkOutput("pre_rereq_addr", int_addr, 8'h24);
      ackCycle();
      src[1] = 1'b0; src[4] = 1'b0;
      writeReg(5'd1, 8'h00);
      writeReg(5'd4, 8'h00);

      // level source with a reprogrammed vector
      writeReg(5'd14, 8'h99);
      checkReg("vec_rd", 5'd14, 8'h99);
      writeReg(5'd6, 8'h04);
      src[6] = 1'b1;
      applyStimulus(2);
      checkOutput("lvl_irq", {7'd0, irq}, 8'h01);
      checkOutput("lvl_lvl", {5'd0, int_lvl}, 8'h04);
      checkOutput("lvl_addr", int_addr, 8'h99);
      irq_ack = 1'b1;
      applyStimulus(1);
      checkOutput("lvl_ack_irq", {7'd0, irq}, 8'h00);
      checkReg("lvl_pend_kept", 5'd16, 8'h40);
      irq_ack = 1'b0;
      applyStimulus(2);
      checkOutput("lvl_reassert", {7'd0, irq}, 8'h01);
      src[6] = 1'b0;
      applyStimulus(2);
      checkOutput("lvl_drop", {7'd0, irq}, 8'h00);
      writeReg(5'd6, 8'h00);

      // cen gating: edge held while cen=0 is not lost
      writeReg(5'd2, 8'h0D);
      cen = 1'b0;
      src[2] = 1'b1;
      applyStimulus(3);
      checkReg("cen_pend_hold", 5'd16, 8'h00);
      checkOutput("cen_irq_hold", {7'd0, irq}, 8'h00);
      cen = 1'b1;
      applyStimulus(2);
      checkOutput("cen_irq", {7'd0, irq}, 8'h01);
      checkOutput("cen_addr", int_addr, 8'h28);
      ackCycle();
      src[2] = 1'b0;
      writeReg(5'd2, 8'h00);

      // collision: new edge on the same cen as the ack clear
      writeReg(5'd3, 8'h0B);
      src[3] = 1'b1;
      applyStimulus(1);
      src[3] = 1'b0;
      applyStimulus(1);
      checkOutput("col_irq", {7'd0, irq}, 8'h01);
      src[3] = 1'b1;
      irq_ack = 1'b1;
      applyStimulus(1);
      checkReg("col_ack_pend", 5'd16, 8'h08);
      checkOutput("col_ack_irq", {7'd0, irq}, 8'h00);
      irq_ack = 1'b0;
      src[3] = 1'b0;
      applyStimulus(1);

      // collision: new edge on the same cen as a W1C write
      src[3] = 1'b1;
      writeReg(5'd16, 8'h08);
      checkReg("col_w1c_pend", 5'd16, 8'h08);
      src[3] = 1'b0;
      applyStimulus(1);
      writeReg(5'd16, 8'h08);
      checkReg("w1c_clear", 5'd16, 8'h00);
      applyStimulus(1);

      // reset in ACK aborts to IDLE, even with cen low
      src[3] = 1'b1;
      applyStimulus(2);
      irq_ack = 1'b1;
      applyStimulus(1);
      cen = 1'b0;
      rst_n = 1'b0;
      applyStimulus(1);
      checkOutput("rstack_irq", {7'd0, irq}, 8'h00);
      checkOutput("rstack_addr", int_addr, 8'h00);
      checkReg("rstack_prio", 5'd3, 8'h00);
      rst_n = 1'b1; cen = 1'b1; irq_ack = 1'b0; src[3] = 1'b0;
      applyStimulus(2);
      checkOutput("rstack_idle", {7'd0, irq}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
